// File: rtl/voice_alloc.sv
// voice_alloc: NCO voice allocator with per-voice age ranking and a 3-state scan FSM.
// Optional VOICE_STEAL_EN: steal the oldest voice instead of dropping a note-on when all voices are busy.
module voice_alloc #(
    parameter int NVOICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    output logic [7*NVOICE-1:0]   voice_note,
    output logic [7*NVOICE-1:0]   voice_vel,
    output logic [NVOICE-1:0]     voice_gate,
    output logic                  drop
);
    localparam int AW = $clog2(NVOICE);
    localparam logic [AW-1:0] LAST = AW'(NVOICE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, match_v, free_v, old_v, tgt;
    logic            match_hit, free_hit;
    logic            cap_on;
    logic [6:0]      cap_note, cap_vel;
    logic [NVOICE-1:0] off_mask, gate;
    logic [6:0]      note [NVOICE];
    logic [6:0]      vel  [NVOICE];
    logic [AW-1:0]   age  [NVOICE];
    logic            take, note_on, alloc;

    assign ev_ready = state == IDLE && !rst;
    assign take     = ev_valid && ev_ready;
    assign note_on  = cap_on && cap_vel != 7'd0;
    assign tgt      = match_hit ? match_v : free_hit ? free_v : old_v;
`ifdef VOICE_STEAL_EN
    assign alloc    = note_on;
`else
    assign alloc    = note_on && (match_hit || free_hit);
`endif
    assign drop       = state == COMMIT && note_on && !alloc;
    assign voice_gate = gate;

    for (genvar i = 0; i < NVOICE; i++) begin : g_pack
        assign voice_note[7*i +: 7] = note[i];
        assign voice_vel[7*i +: 7]  = vel[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (take ? SCAN : IDLE) :
                    state == SCAN ? (idx == LAST ? COMMIT : SCAN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            match_v   <= '0;
            free_v    <= '0;
            old_v     <= '0;
            match_hit <= 1'b0;
            free_hit  <= 1'b0;
            off_mask  <= '0;
            cap_on    <= 1'b0;
            cap_note  <= '0;
            cap_vel   <= '0;
            gate      <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                note[i] <= '0;
                vel[i]  <= '0;
                age[i]  <= AW'(i);
            end
        end else begin
            if (take) begin
                cap_on    <= ev_on;
                cap_note  <= ev_note;
                cap_vel   <= ev_vel;
                idx       <= '0;
                match_hit <= 1'b0;
                free_hit  <= 1'b0;
                off_mask  <= '0;
            end
            if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (gate[idx] && note[idx] == cap_note) begin
                    off_mask[idx] <= 1'b1;
                    if (!match_hit) begin
                        match_hit <= 1'b1;
                        match_v   <= idx;
                    end
                end
                if (!gate[idx] && !free_hit) begin
                    free_hit <= 1'b1;
                    free_v   <= idx;
                end
                if (age[idx] == LAST) old_v <= idx;
            end
            // Voice state only ever changes here, so the scan sees a stable snapshot.
            if (state == COMMIT) begin
                if (alloc) begin
                    for (int i = 0; i < NVOICE; i++) begin
                        if (AW'(i) == tgt) begin
                            note[i] <= cap_note;
                            vel[i]  <= cap_vel;
                            gate[i] <= 1'b1;
                            age[i]  <= '0;
                        end else if (age[i] < age[tgt]) begin
                            age[i] <= age[i] + 1'b1;
                        end
                    end
                end else if (!note_on) begin
                    gate <= gate & ~off_mask;
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed and random note events checked against a behavioural voice model.
module tb_voice_alloc;
    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ev_valid = 1'b0;
    logic            ev_ready;
    logic            ev_on = 1'b0;
    logic [6:0]      ev_note = '0;
    logic [6:0]      ev_vel = '0;
    logic [7*NV-1:0] voice_note, voice_vel;
    logic [NV-1:0]   voice_gate;
    logic            drop;

    int checks = 0;
    int errors = 0;
    int m_note [NV];
    int m_vel  [NV];
    int m_age  [NV];
    bit m_gate [NV];

    voice_alloc #(.NVOICE(NV)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel),
        .voice_note(voice_note), .voice_vel(voice_vel),
        .voice_gate(voice_gate), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_age[i] = i;
        end
    endfunction

    // Returns 1 when the event is expected to be discarded with a DROP pulse.
    function automatic bit m_event(input bit on, input int n, input int v);
        int t;
        int a;
        t = -1;
        if (on && v != 0) begin
            for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) begin
`ifdef VOICE_STEAL_EN
                for (int i = 0; i < NV; i++) if (m_age[i] == NV - 1) t = i;
`else
                return 1'b1;
`endif
            end
            a = m_age[t];
            for (int i = 0; i < NV; i++) if (m_age[i] < a) m_age[i]++;
            m_age[t] = 0; m_note[t] = n; m_vel[t] = v; m_gate[t] = 1;
        end else begin
            for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
        end
        return 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        logic [7*NV-1:0] en, ev;
        logic [NV-1:0]   eg;
        logic [31:0]     ea, oa;
        en = '0; ev = '0; eg = '0; ea = '0; oa = '0;
        for (int i = 0; i < NV; i++) begin
            en[7*i +: 7] = 7'(m_note[i]);
            ev[7*i +: 7] = 7'(m_vel[i]);
            eg[i]        = m_gate[i];
            ea[4*i +: 4] = 4'(m_age[i]);
            oa[4*i +: 4] = 4'(dut.age[i]);
        end
        check({tag, " gate"}, 64'(voice_gate), 64'(eg));
        check({tag, " note"}, 64'(voice_note), 64'(en));
        check({tag, " vel"},  64'(voice_vel),  64'(ev));
        check({tag, " age"},  64'(oa), 64'(ea));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ev_valid = 1'b0;
        @(negedge clk);
        check("ready in reset", 64'(ev_ready), 64'd0);
        check("drop in reset", 64'(drop), 64'd0);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        check("ready after reset", 64'(ev_ready), 64'd1);
    endtask

    task automatic offer(input bit on, input int n, input int v, output bit ok);
        int w;
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(n); ev_vel = 7'(v);
        w = 0;
        while (!ev_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = ev_ready;
        if (!ok) begin
            check("ready timeout", 64'(ev_ready), 64'd1);
            ev_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic send(input string tag, input bit on, input int n, input int v);
        bit ok, exp_drop;
        int lowcnt, drops;
        offer(on, n, v, ok);
        if (!ok) return;
        exp_drop = m_event(on, n, v);
        lowcnt = 0; drops = 0;
        while (!ev_ready && lowcnt < 3 * NV) begin
            lowcnt++;
            drops += int'(drop);
            @(negedge clk);
        end
        check({tag, " ready low cycles"}, 64'(lowcnt), 64'(NV + 1));
        check({tag, " drop pulses"}, 64'(drops), 64'(exp_drop));
        compare_all(tag);
    endtask

    task automatic fill4();
        do_reset();
        send("fill60", 1, 60, 100);
        send("fill62", 1, 62, 100);
        send("fill64", 1, 64, 100);
        send("fill65", 1, 65, 100);
        check("fill gate const", 64'(voice_gate), 64'hF);
        check("fill notes const", 64'(voice_note), 64'({7'd65, 7'd64, 7'd62, 7'd60}));
    endtask

    initial begin
        bit ok;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare_all("reset");
        check("reset ready", 64'(ev_ready), 64'd1);

        send("first on", 1, 50, 127);
        check("first gate const", 64'(voice_gate), 64'h1);
        check("first note const", 64'(voice_note[6:0]), 64'd50);
        check("first vel const", 64'(voice_vel[6:0]), 64'd127);

        fill4();
        send("full 67", 1, 67, 90);

        fill4();
        send("off 62 by vel0", 1, 62, 0);
        check("off gate const", 64'(voice_gate), 64'hD);
        send("on 70", 1, 70, 100);
        check("on70 note const", 64'(voice_note[13:7]), 64'd70);

        fill4();
        send("retrig 64", 1, 64, 20);
        check("retrig vel const", 64'(voice_vel[20:14]), 64'd20);
        send("off 99", 0, 99, 0);

        do_reset();
        send("pre abort", 1, 40, 10);
        offer(1, 41, 11, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ready", 64'(ev_ready), 64'd0);
        check("abort drop", 64'(drop), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        check("abort ready after", 64'(ev_ready), 64'd1);
        compare_all("abort");

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else send("rand", 1'($urandom_range(0, 2) != 0), int'($urandom_range(58, 64)),
                      $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, 127)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NVOICE, default 4, number of NCO voices managed; legal values 2..8.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 EV_VALID  input  1  note event offered.
REQ-005 EV_READY  output  1  block can accept an event; transfer occurs when EV_VALID and EV_READY are both high at a rising edge.
REQ-006 EV_ON  input  1  1 = note-on, 0 = note-off.
REQ-007 EV_NOTE  input  7  MIDI note number.
REQ-008 EV_VEL  input  7  MIDI velocity.
REQ-009 VOICE_NOTE  output  7*NVOICE  per-voice NOTE_NUM to NCO; voice i at bits [7i+6:7i].
REQ-010 VOICE_VEL  output  7*NVOICE  per-voice NOTE_VEL to NCO, same packing.
REQ-011 VOICE_GATE  output  NVOICE  per-voice active flag; drives NCO CE.
REQ-012 DROP  output  1  one-cycle pulse when a note-on is discarded.

Function
REQ-013 FSM states: IDLE, SCAN, COMMIT; EV_READY SHALL be high only in IDLE.
REQ-014 IDLE: on transfer, capture EV_ON/EV_NOTE/EV_VEL, clear scan index, go to SCAN.
REQ-015 SCAN: examine one voice per cycle, index 0..NVOICE-1; after index NVOICE-1 go to COMMIT (exactly NVOICE cycles).
REQ-016 COMMIT: apply the decision, return to IDLE; outputs change at the COMMIT edge; EV_READY low for NVOICE+1 cycles after each transfer.
REQ-017 Note-on with EV_VEL=0 SHALL be treated as note-off.
REQ-018 Note-on priority: (a) lowest-index gated voice with matching note, retriggered with new velocity; (b) else lowest-index ungated voice; (c) else steal per REQ-026/027.
REQ-019 Allocated/retriggered voice: note and velocity loaded, gate set, age set to 0.
REQ-020 Ages: per-voice rank 0..NVOICE-1 (0 = newest), always a permutation; on allocation of voice v with old age a, every voice with age < a increments.
REQ-021 Note-off: clear gate of every gated voice whose note matches; note, velocity, ages unchanged; no match = no effect, no DROP.
REQ-022 Note and velocity registers of ungated voices hold their last values.

Reset
REQ-023 While RST high: state IDLE, EV_READY low, captured event discarded, DROP 0.
REQ-024 Reset values: VOICE_GATE all 0, VOICE_NOTE 0, VOICE_VEL 0, age of voice i = i.
REQ-025 Reset mid-SCAN/COMMIT SHALL abort the event with no voice update; EV_READY high on the first edge after RST falls.

Configuration
REQ-026 With VOICE_STEAL_EN defined: note-on with all voices gated and no note match steals the voice with age NVOICE-1 (oldest), per REQ-019; DROP stays 0.
REQ-027 Without VOICE_STEAL_EN: that note-on is discarded, no voice changes, DROP pulses high in the COMMIT cycle.

Verification (NVOICE=4)
REQ-028 Reset release, note-on 50 vel 127 -> EV_READY low 5 cycles, then voice0 note 50 vel 127, GATE=0001, voice0 age 0.
REQ-029 Note-ons 60,62,64,65 (vel 100) -> GATE=1111, voices 0..3 hold 60,62,64,65; ages 3,2,1,0.
REQ-030 From REQ-029, note-on 67 vel 90 -> with VOICE_STEAL_EN voice0 becomes 67/90, age 0; without it, no change and one DROP pulse.
REQ-031 From REQ-029, note-on 62 vel 0 -> voice1 gate clears, GATE=1101; then note-on 70 -> voice1 = 70, GATE=1111.
REQ-032 From REQ-029, note-on 64 vel 20 -> voice2 velocity 20, age 0, no other voice changes; then note-off 99 -> no change, no DROP.
REQ-033 Assert RST during SCAN of a note-on -> after release GATE=0000, all notes/velocities 0, ages 0,1,2,3.
